ls_univ_shift_n: RTL and testbench
==================================

Name: ls_univ_shift_n

Overview:
Parametrised successor to the 74LS-series gate models: an N-bit universal shift register in the style of the 74LS194, generalised in width. It adds rotate, arithmetic-shift and synchronous-clear modes. It also adds a sequenced multi-position shift with a busy/done handshake. It sits in the CPU datapath as a shifter/rotator building block alongside the TTL-equivalent gate models.

Parameters:
WIDTH, 4, register width in bits (>= 2)
CNT_W, 3, width of the shift-amount input; maximum sequenced shift is 2^CNT_W-1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  3  operation select (encoding below)
start  input  1  begin an operation; sampled only when idle
amt  input  CNT_W  number of single-bit steps for shift/rotate modes
d  input  WIDTH  parallel load data
sr_in  input  1  serial input for shift-right (enters the MSB)
sl_in  input  1  serial input for shift-left (enters the LSB)
q  output  WIDTH  register contents
busy  output  1  high while a sequenced operation is in progress
done  output  1  one-cycle pulse on the cycle the operation completes

Behaviour:
- Reset (rst_n low, asynchronous): q=0, busy=0, done=0, internal counter=0, FSM=IDLE. Takes effect immediately, including mid-operation; the operation in progress is abandoned with no done pulse.
- Mode encoding:
  - 000 HOLD
  - 001 SHR: q <= {sr_in, q[W-1:1]}
  - 010 SHL: q <= {q[W-2:0], sl_in}
  - 011 LOAD: q <= d
  - 100 ROR: q <= {q[0], q[W-1:1]}
  - 101 ROL: q <= {q[W-2:0], q[W-1]}
  - 110 ASR: q <= {q[W-1], q[W-1:1]}
  - 111 CLR: q <= 0
- FSM states: IDLE and RUN.
- IDLE:
  - start=0: q holds, done=0.
  - start=1 with LOAD, CLR or HOLD: apply in one edge, stay IDLE, done=1 next cycle, busy stays 0.
  - start=1 with a shift/rotate mode and amt=0: treated as HOLD; done=1 next cycle.
  - start=1 with a shift/rotate mode and amt>0: latch mode and serial-input selection into internal registers. Perform the first step on the same edge, load counter=amt-1, go to RUN if amt>1, else stay IDLE with done.
- RUN:
  - busy=1.
  - One step per clock using the latched mode.
  - sr_in/sl_in are sampled live each step, so serial streams can be fed in.
  - Counter decrements; when the counter is 0 at an edge, perform the last step and return to IDLE. done=1 in the following cycle, busy=0.
- Total latency: amt edges for amt>=1. q reflects step k after edge k.
- start, mode, amt and d are ignored while busy=1. A start coincident with the done cycle (FSM already IDLE) is accepted normally, so back-to-back operations lose no cycles.
- done is registered, high exactly one cycle per completed operation, and never high together with busy.
- All arithmetic is unsigned on the counter. No wrap: the counter stops at 0.

Decomposition:
- Shared package (ls_pkg): mode encoding constants (MODE_HOLD … MODE_CLR) and FSM state constants IDLE/RUN.
- One natural sub-module, ls_shift_step: combinational next-value function of (mode, q, sr_in, sl_in, d) -> q_next, WIDTH-parametrised. The top holds the FSM, counter and registers and instantiates one ls_shift_step.

Test Plan:
- Async reset: drive q to 4'b1011, assert rst_n low between clock edges -> q=0, busy=0, done=0 immediately, before the next edge.
- LOAD: WIDTH=4, d=4'b1010, mode=011, start=1 -> q=1010 after 1 edge, done=1 for one cycle, busy never high.
- ROL sequence: q=1000, mode=101, amt=3, start -> q=0001, 0010, 0100 on edges 1-3; busy high cycles 1-2; done on cycle 3. Change mode/d mid-run -> no effect.
- SHR serial stream: q=0000, mode=001, amt=4, sr_in=1,0,1,1 on successive edges -> q=1000, 0100, 1010, 1101.
- ASR sign extension: WIDTH=8, q=8'h90, mode=110, amt=3 -> q=8'hF2 with done after 3 edges. Also amt=0 -> q unchanged, done pulse.
- Reset mid-RUN: ROR with amt=5, assert rst_n low after edge 2 -> q=0, busy=0, no done. Back-to-back: start asserted in the done cycle -> new operation begins with no idle gap.

Source files
------------

// File: rtl/ls_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ls_pkg
//  Description : Shared definitions for the universal shift register:
//                operation-mode encoding, FSM state type and a helper that
//                classifies modes as sequenced (multi-step) or single-edge.
//  Revision    : 1.0  initial release
// ============================================================================
package ls_pkg;

    // Operation-mode encoding (3-bit mode input)
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    // Sequencer states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Shift/rotate modes honour the amount input and may take several edges.
    // HOLD, LOAD and CLR always complete in a single edge.
    function automatic logic is_seq_mode(input logic [2:0] m);
        return !((m == MODE_HOLD) || (m == MODE_LOAD) || (m == MODE_CLR));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ls_shift_step.sv
`default_nettype none
// ============================================================================
//  Module      : ls_shift_step
//  Description : Combinational single-step next-value function of the
//                universal shift register.
//  Ports       : mode_i    - operation select
//                q_i       - current register contents
//                sr_in_i   - serial input entering the MSB on SHR
//                sl_in_i   - serial input entering the LSB on SHL
//                d_i       - parallel load data
//                q_next_o  - register value after one step
//  Revision    : 1.0  initial release
// ============================================================================
module ls_shift_step
    import ls_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             sr_in_i,
    input  logic             sl_in_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_next_o
);

    always_comb begin
        q_next_o = q_i;
        case (mode_i)
            MODE_HOLD: q_next_o = q_i;
            MODE_SHR:  q_next_o = {sr_in_i, q_i[WIDTH-1:1]};
            MODE_SHL:  q_next_o = {q_i[WIDTH-2:0], sl_in_i};
            MODE_LOAD: q_next_o = d_i;
            MODE_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
            MODE_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            // Sign bit is replicated into the vacated MSB.
            MODE_ASR:  q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            MODE_CLR:  q_next_o = '0;
            default:   q_next_o = q_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ls_univ_shift_n.sv
`default_nettype none
// ============================================================================
//  Module      : ls_univ_shift_n
//  Description : N-bit universal shift register (74LS194 style) with rotate,
//                arithmetic shift, synchronous clear and a sequenced
//                multi-position shift using a busy/done handshake.
//  Ports       : clk      - rising-edge clock
//                rst_n    - asynchronous active-low reset
//                mode_i   - operation select
//                start_i  - begin an operation (sampled only when idle)
//                amt_i    - number of single-bit steps for shift/rotate
//                d_i      - parallel load data
//                sr_in_i  - serial input for shift-right (enters MSB)
//                sl_in_i  - serial input for shift-left (enters LSB)
//                q_o      - register contents
//                busy_o   - sequenced operation in progress
//                done_o   - one-cycle pulse after an operation completes
//  Revision    : 1.0  initial release
// ============================================================================
module ls_univ_shift_n
    import ls_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] amt_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sr_in_i,
    input  logic             sl_in_i,
    output logic [WIDTH-1:0] q_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         mode_q, mode_d;
    logic               done_q, done_d;

    logic [2:0]         step_mode;
    logic [WIDTH-1:0]   q_next;

    // Single shared step function; the sequencer only chooses which mode
    // it evaluates on each edge (HOLD whenever nothing should change).
    ls_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode_i   (step_mode),
        .q_i      (q_q),
        .sr_in_i  (sr_in_i),
        .sl_in_i  (sl_in_i),
        .d_i      (d_i),
        .q_next_o (q_next)
    );

    // cnt_q holds the number of steps still to perform after the current
    // edge, so an operation of amt steps occupies exactly amt edges.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        step_mode = MODE_HOLD;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    done_d = 1'b1;
                    if (is_seq_mode(mode_i)) begin
                        if (amt_i != '0) begin
                            step_mode = mode_i;
                            mode_d    = mode_i;
                            cnt_d     = amt_i - CNT_W'(1);
                            if (amt_i > CNT_W'(1)) begin
                                state_d = RUN;
                                done_d  = 1'b0;
                            end
                        end
                        // amt of zero: register held, done still pulses
                    end else begin
                        step_mode = mode_i;
                    end
                end
            end
            RUN: begin
                // Latched mode; serial inputs are taken live every step.
                step_mode = mode_q;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        q_d = q_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign q_o    = q_q;
    assign busy_o = (state_q == RUN);
    assign done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ls_univ_shift_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ls_univ_shift_n
//  Description : Self-checking bench for ls_univ_shift_n. Stimulus pushes the
//                expected final value and latency of each operation into a
//                queue; monitors pop and compare on every done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ls_univ_shift_n;
    import ls_pkg::*;

    typedef struct {
        logic [7:0] q;
        int         lat;
        int         t0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_tot = 0;

    exp_t       sb4[$];
    exp_t       sb8[$];

    // 4-bit instance
    logic [2:0] mode4 = '0;
    logic       start4 = 1'b0;
    logic [2:0] amt4 = '0;
    logic [3:0] d4 = '0;
    logic       sr4 = 1'b0;
    logic       sl4 = 1'b0;
    logic [3:0] q4;
    logic       busy4, done4;

    // 8-bit instance
    logic [2:0] mode8 = '0;
    logic       start8 = 1'b0;
    logic [2:0] amt8 = '0;
    logic [7:0] d8 = '0;
    logic [7:0] q8;
    logic       busy8, done8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ls_univ_shift_n #(.WIDTH(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode4), .start_i(start4),
        .amt_i(amt4), .d_i(d4), .sr_in_i(sr4), .sl_in_i(sl4),
        .q_o(q4), .busy_o(busy4), .done_o(done4)
    );

    ls_univ_shift_n #(.WIDTH(8), .CNT_W(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode8), .start_i(start8),
        .amt_i(amt8), .d_i(d8), .sr_in_i(1'b0), .sl_in_i(1'b0),
        .q_o(q8), .busy_o(busy8), .done_o(done8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitors: sample 1 time unit after the rising edge.
    always @(posedge clk) begin
        #1;
        if (done4) begin
            if (busy4) chk("dut4 done with busy", 32'(busy4), 32'd0);
            if (sb4.size() == 0) begin
                chk("dut4 unexpected done", 32'(done4), 32'd0);
            end else begin
                exp_t e;
                e = sb4.pop_front();
                chk("dut4 result q", {28'd0, q4}, {24'd0, e.q});
                chk("dut4 latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
        if (done8) begin
            if (sb8.size() == 0) begin
                chk("dut8 unexpected done", 32'(done8), 32'd0);
            end else begin
                exp_t e;
                e = sb8.pop_front();
                chk("dut8 result q", {24'd0, q8}, {24'd0, e.q});
                chk("dut8 latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    // Drive a start at the current negedge, return at the negedge after the
    // sampling edge.
    task automatic kick4(input logic [2:0] m, input logic [2:0] a, input logic [3:0] dd,
                         input logic [3:0] eq, input int lat, input bit exp_done);
        mode4 = m; amt4 = a; d4 = dd; start4 = 1'b1;
        if (exp_done) sb4.push_back('{q: {4'd0, eq}, lat: lat, t0: cyc});
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic kick8(input logic [2:0] m, input logic [2:0] a, input logic [7:0] dd,
                         input logic [7:0] eq, input int lat);
        mode8 = m; amt8 = a; d8 = dd; start8 = 1'b1;
        sb8.push_back('{q: eq, lat: lat, t0: cyc});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy4 && !busy8 && sb4.size() == 0 && sb8.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_idle timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset q", {28'd0, q4}, 32'd0);
        chk("reset busy", 32'(busy4), 32'd0);
        chk("reset done", 32'(done4), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset between edges, while done is high
        kick4(MODE_LOAD, 3'd0, 4'b1011, 4'b1011, 1, 1'b1);
        chk("pre-reset q", {28'd0, q4}, 32'hB);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset q", {28'd0, q4}, 32'd0);
        chk("async reset busy", 32'(busy4), 32'd0);
        chk("async reset done", 32'(done4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // LOAD: one edge, busy never high, done one cycle
        kick4(MODE_LOAD, 3'd0, 4'b1010, 4'b1010, 1, 1'b1);
        chk("load q", {28'd0, q4}, 32'hA);
        chk("load busy", 32'(busy4), 32'd0);
        chk("load done", 32'(done4), 32'd1);
        @(negedge clk);
        chk("load done drops", 32'(done4), 32'd0);

        // ROL x3 from 1000, inputs disturbed mid-run
        kick4(MODE_LOAD, 3'd0, 4'b1000, 4'b1000, 1, 1'b1);
        kick4(MODE_ROL, 3'd3, 4'b0000, 4'b0100, 3, 1'b1);
        chk("rol step1 q", {28'd0, q4}, 32'h1);
        chk("rol step1 busy", 32'(busy4), 32'd1);
        mode4 = MODE_LOAD; d4 = 4'b1111; amt4 = 3'd7; start4 = 1'b1;
        @(negedge clk);
        chk("rol step2 q", {28'd0, q4}, 32'h2);
        chk("rol step2 busy", 32'(busy4), 32'd1);
        @(negedge clk);
        start4 = 1'b0;
        chk("rol step3 q", {28'd0, q4}, 32'h4);
        chk("rol step3 busy", 32'(busy4), 32'd0);
        chk("rol step3 done", 32'(done4), 32'd1);
        wait_idle();

        // SHR with serial stream 1,0,1,1 after CLR
        kick4(MODE_CLR, 3'd0, 4'b0110, 4'b0000, 1, 1'b1);
        sr4 = 1'b1;
        kick4(MODE_SHR, 3'd4, 4'b0000, 4'b1101, 4, 1'b1);
        chk("shr step1", {28'd0, q4}, 32'h8);
        sr4 = 1'b0;
        @(negedge clk);
        chk("shr step2", {28'd0, q4}, 32'h4);
        sr4 = 1'b1;
        @(negedge clk);
        chk("shr step3", {28'd0, q4}, 32'hA);
        sr4 = 1'b1;
        @(negedge clk);
        chk("shr step4", {28'd0, q4}, 32'hD);
        sr4 = 1'b0;
        wait_idle();

        // 8-bit ASR: 0x90 >>> 3 = 0xF2, then amt=0 holds
        kick8(MODE_LOAD, 3'd0, 8'h90, 8'h90, 1);
        kick8(MODE_ASR, 3'd3, 8'h00, 8'hF2, 3);
        wait_idle();
        kick8(MODE_ASR, 3'd0, 8'h00, 8'hF2, 1);
        wait_idle();

        // Maximum amount: ROR by 7 on 1001 equals rotate left by one -> 0011
        kick4(MODE_LOAD, 3'd0, 4'b1001, 4'b1001, 1, 1'b1);
        kick4(MODE_ROR, 3'd7, 4'b0000, 4'b0011, 7, 1'b1);
        wait_idle();

        // HOLD with start: q unchanged, done pulse
        kick4(MODE_HOLD, 3'd5, 4'b1111, 4'b0011, 1, 1'b1);
        wait_idle();

        // Reset mid-RUN: ROR x5 from 0001, abort after edge 2, no done
        kick4(MODE_LOAD, 3'd0, 4'b0001, 4'b0001, 1, 1'b1);
        kick4(MODE_ROR, 3'd5, 4'b0000, 4'b0000, 0, 1'b0);
        @(negedge clk);
        chk("ror edge2 q", {28'd0, q4}, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun reset q", {28'd0, q4}, 32'd0);
        chk("midrun reset busy", 32'(busy4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no done after abort", 32'(done4), 32'd0);

        // Back-to-back: SHL x2 with sl_in=1 on 0011 -> 1111, LOAD in done cycle
        kick4(MODE_LOAD, 3'd0, 4'b0011, 4'b0011, 1, 1'b1);
        sl4 = 1'b1;
        kick4(MODE_SHL, 3'd2, 4'b0000, 4'b1111, 2, 1'b1);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 16; i++) begin
                if (done4) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("b2b done seen", 32'(seen), 32'd1);
        end
        sl4 = 1'b0;
        kick4(MODE_LOAD, 3'd0, 4'b0101, 4'b0101, 1, 1'b1);
        chk("b2b load q", {28'd0, q4}, 32'h5);
        wait_idle();

        chk("scoreboard drained", 32'(sb4.size() + sb8.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
